// File: rtl/sd_card_pkg.sv
// Shared definitions for the SD card-side command responder: FSM states,
// response frame lengths and the CRC7 (x^7 + x^3 + 1) serial step.
package sd_card_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    CHECK,
    WAIT,
    TX
  } sd_state_e;

  localparam int R1_LEN = 48;
  localparam int R2_LEN = 136;

  // x^7 + x^3 + 1 with the x^7 term implied by the shift
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // One bit of the MSB-first CRC7 recurrence.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Serial CRC7 accumulator. clr has priority over en; the register holds
// its value whenever neither is asserted.
module sd_crc7_serial
  import sd_card_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  // CRC register: clear, advance by one bit, or hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 7'h00;
    end else if (clr) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= crc7_next(crc, din);
    end
  end

endmodule

// File: rtl/sd_cmd_card_responder.sv
// Card-side model of the SD CMD line. Receives 48-bit host command tokens,
// checks direction, CRC7 and end bit, and answers with an R1 response after
// NCR released cycles. Optional feature macro SDC_RSP_LONG_EN: indices 2, 9
// and 10 are answered with a 136-bit R2 built from rsp_long_i.
module sd_cmd_card_responder
  import sd_card_pkg::*;
#(
  parameter int NCR = 2
)
(
  input  logic         sd_clk_i,
  input  logic         wb_rst_i,
  input  logic         sd_cmd_dat_i,
  output logic         sd_cmd_out_o,
  output logic         sd_cmd_oe_o,
  output logic         cmd_valid_o,
  output logic [5:0]   cmd_index_o,
  output logic [31:0]  cmd_arg_o,
  output logic         cmd_err_o,
  output logic         busy_o,
  input  logic [31:0]  rsp_arg_i
`ifdef SDC_RSP_LONG_EN
  ,
  input  logic [127:0] rsp_long_i
`endif
);

`ifdef SDC_RSP_LONG_EN
  localparam int TXW = 8;
  localparam int SHW = 128;
`else
  localparam int TXW = 6;
  localparam int SHW = 40;
`endif

  sd_state_e        state_q, state_d;
  logic [5:0]       rx_cnt_q, rx_cnt_d;
  logic [46:0]      rx_shift_q, rx_shift_d;
  logic [6:0]       wait_cnt_q, wait_cnt_d;
  logic [TXW-1:0]   tx_pos_q, tx_pos_d, tx_nxt;
  logic [SHW-1:0]   tx_shift_q, tx_shift_d;
  logic             out_q, out_d;
  logic             oe_q, oe_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [5:0]       idx_q, idx_d;
  logic [31:0]      arg_q, arg_d;
  logic             crc_clr, crc_en, crc_din;
  logic [6:0]       crc_q;
  logic [SHW-1:0]   frame;
  logic [TXW-1:0]   tx_last, crc_start, crc_first;
`ifdef SDC_RSP_LONG_EN
  logic             long_q, long_d;
  logic             is_long;
`endif

  // Single CRC engine: checks the received token, then generates the response CRC
  sd_crc7_serial u_crc (
    .clk (sd_clk_i),
    .rst (wb_rst_i),
    .clr (crc_clr),
    .en  (crc_en),
    .din (crc_din),
    .crc (crc_q)
  );

`ifdef SDC_RSP_LONG_EN
  // Response framing: R2 for CID/CSD indices, otherwise R1 left-aligned
  always_comb begin
    is_long   = (idx_q == 6'd2) || (idx_q == 6'd9) || (idx_q == 6'd10);
    frame     = is_long ? {2'b00, 6'h3f, rsp_long_i[127:8]}
                        : {2'b00, idx_q, rsp_arg_i, 88'h0};
    tx_last   = long_q ? TXW'(R2_LEN - 1) : TXW'(R1_LEN - 1);
    crc_start = long_q ? TXW'(128) : TXW'(40);
    crc_first = long_q ? TXW'(8) : TXW'(1);
  end
`else
  // Response framing: R1 header and card status
  always_comb begin
    frame     = {2'b00, idx_q, rsp_arg_i};
    tx_last   = TXW'(R1_LEN - 1);
    crc_start = TXW'(40);
    crc_first = TXW'(1);
  end
`endif

  // Next-state and next-output logic for the command/response FSM
  always_comb begin
    state_d    = state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    wait_cnt_d = wait_cnt_q;
    tx_pos_d   = tx_pos_q;
    tx_shift_d = tx_shift_q;
    out_d      = out_q;
    oe_d       = oe_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    idx_d      = idx_q;
    arg_d      = arg_q;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    crc_din    = sd_cmd_dat_i;
    tx_nxt     = tx_pos_q + 1'b1;
`ifdef SDC_RSP_LONG_EN
    long_d     = long_q;
`endif
    case (state_q)
      IDLE: begin
        crc_clr = 1'b1;
        oe_d    = 1'b0;
        out_d   = 1'b1;
        if (!sd_cmd_dat_i) begin
          state_d  = RX;
          rx_cnt_d = 6'd47;
        end
      end
      RX: begin
        rx_shift_d = {rx_shift_q[45:0], sd_cmd_dat_i};
        rx_cnt_d   = rx_cnt_q - 1'b1;
        // transmission bit, index and argument feed the CRC; crc and end bit do not
        crc_en     = (rx_cnt_q > 6'd8);
        if (rx_cnt_q == 6'd1) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        crc_clr = 1'b1;
        state_d = IDLE;
        // a token with direction bit 0 came from another card: ignore it
        if (rx_shift_q[46]) begin
          if ((rx_shift_q[7:1] != crc_q) || !rx_shift_q[0]) begin
            err_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            idx_d   = rx_shift_q[45:40];
            arg_d   = rx_shift_q[39:8];
            if (rx_shift_q[45:40] != 6'd0) begin
              state_d    = WAIT;
              wait_cnt_d = 7'(NCR - 1);
            end
          end
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 1'b1;
        if (wait_cnt_q == 7'd0) begin
          state_d    = TX;
          tx_pos_d   = '0;
          tx_shift_d = {frame[SHW-2:0], 1'b0};
          out_d      = frame[SHW-1];
          oe_d       = 1'b1;
`ifdef SDC_RSP_LONG_EN
          long_d     = is_long;
`endif
        end
      end
      TX: begin
        if (tx_pos_q == tx_last) begin
          oe_d    = 1'b0;
          out_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tx_pos_d = tx_nxt;
          crc_din  = tx_shift_q[SHW-1];
          crc_en   = (tx_nxt >= crc_first) && (tx_nxt < crc_start);
          if (tx_nxt == crc_start) begin
            // CRC is complete: send its MSB now and queue the rest plus the end bit
            out_d      = crc_q[6];
            tx_shift_d = {crc_q[5:0], 1'b1, {(SHW-7){1'b0}}};
          end else begin
            out_d      = tx_shift_q[SHW-1];
            tx_shift_d = {tx_shift_q[SHW-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset releases the line immediately
  always_ff @(posedge sd_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      wait_cnt_q <= '0;
      tx_pos_q   <= '0;
      tx_shift_q <= '0;
      out_q      <= 1'b1;
      oe_q       <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      arg_q      <= '0;
`ifdef SDC_RSP_LONG_EN
      long_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      wait_cnt_q <= wait_cnt_d;
      tx_pos_q   <= tx_pos_d;
      tx_shift_q <= tx_shift_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
`ifdef SDC_RSP_LONG_EN
      long_q     <= long_d;
`endif
    end
  end

  assign sd_cmd_out_o = out_q;
  assign sd_cmd_oe_o  = oe_q;
  assign cmd_valid_o  = valid_q;
  assign cmd_err_o    = err_q;
  assign cmd_index_o  = idx_q;
  assign cmd_arg_o    = arg_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_sd_cmd_card_responder.sv
// Scoreboard bench for sd_cmd_card_responder. Two instances (NCR=2 and
// NCR=8) share the host CMD line; expected command reports and response
// frames are queued as tokens are sent and compared as the DUT produces them.
// Honours SDC_RSP_LONG_EN for the R2 path.
module tb_sd_cmd_card_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         line = 1'b1;
  logic [31:0]  rsp_arg = 32'h0;
  logic [127:0] rsp_long = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  logic        out2, oe2, vld2, err2, busy2;
  logic [5:0]  idx2;
  logic [31:0] arg2;
  logic        out8, oe8, vld8, err8, busy8;
  logic [5:0]  idx8;
  logic [31:0] arg8;

  typedef struct {
    bit          err;
    logic [5:0]  idx;
    logic [31:0] arg;
    int          cyc;
  } cmd_exp_t;

  typedef struct {
    int           len;
    logic [135:0] bits;
    int           cyc;
  } rsp_exp_t;

  cmd_exp_t cmd_q[$];
  rsp_exp_t rsp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_end = 0;
  int dut8_end = 0;
  bit dut8_exp = 1'b0;
  bit in_rsp = 1'b0;
  int oe_hi_cnt = 0;

  sd_cmd_card_responder #(.NCR(2)) dut2 (
    .sd_clk_i     (clk),
    .wb_rst_i     (rst),
    .sd_cmd_dat_i (line),
    .sd_cmd_out_o (out2),
    .sd_cmd_oe_o  (oe2),
    .cmd_valid_o  (vld2),
    .cmd_index_o  (idx2),
    .cmd_arg_o    (arg2),
    .cmd_err_o    (err2),
    .busy_o       (busy2),
    .rsp_arg_i    (rsp_arg)
`ifdef SDC_RSP_LONG_EN
    ,
    .rsp_long_i   (rsp_long)
`endif
  );

  sd_cmd_card_responder #(.NCR(8)) dut8 (
    .sd_clk_i     (clk),
    .wb_rst_i     (rst),
    .sd_cmd_dat_i (line),
    .sd_cmd_out_o (out8),
    .sd_cmd_oe_o  (oe8),
    .cmd_valid_o  (vld8),
    .cmd_index_o  (idx8),
    .cmd_arg_o    (arg8),
    .cmd_err_o    (err8),
    .busy_o       (busy8),
    .rsp_arg_i    (rsp_arg)
`ifdef SDC_RSP_LONG_EN
    ,
    .rsp_long_i   (rsp_long)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC7 over the n low bits of v, MSB first.
  function automatic logic [6:0] crc7_ref(input logic [135:0] v, input int n);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = n - 1; i >= 0; i--) begin
      fb = v[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic rsp_exp_t exp_rsp(input logic [5:0] idx, input logic [31:0] a, input int at);
    rsp_exp_t     r;
    logic [135:0] v;
    v     = '0;
    r.cyc = at;
`ifdef SDC_RSP_LONG_EN
    if (idx == 6'd2 || idx == 6'd9 || idx == 6'd10) begin
      v[119:0] = rsp_long[127:8];
      r.len    = 136;
      r.bits   = {2'b00, 6'h3f, rsp_long[127:8], crc7_ref(v, 120), 1'b1};
      return r;
    end
`endif
    v[39:0] = {2'b00, idx, a};
    r.len   = 48;
    r.bits  = {88'h0, v[39:0], crc7_ref(v, 40), 1'b1};
    return r;
  endfunction

  function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] a);
    logic [39:0]  t;
    logic [135:0] v;
    t = {2'b01, idx, a};
    v = '0;
    v[39:0] = t;
    return {t, crc7_ref(v, 40), 1'b1};
  endfunction

  // Host drives one token MSB first; returns at the negedge after the end-bit edge.
  task automatic send(input logic [47:0] tok);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      line = tok[i];
    end
    @(negedge clk);
    line = 1'b1;
    last_end = cyc;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy2 || busy8 || in_rsp) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) check_eq("idle_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic cmd_ok(input logic [47:0] tok, input bit rsp, input bit wait_done);
    cmd_exp_t ce;
    send(tok);
    ce.err = 1'b0;
    ce.idx = tok[45:40];
    ce.arg = tok[39:8];
    ce.cyc = last_end + 1;
    cmd_q.push_back(ce);
    if (rsp) begin
      rsp_q.push_back(exp_rsp(tok[45:40], rsp_arg, last_end + 3));
      dut8_exp = 1'b1;
      dut8_end = last_end;
    end
    check_eq("busy_after_rx", busy2, 1'b1);
    if (wait_done) wait_idle();
  endtask

  task automatic cmd_bad(input logic [47:0] tok);
    cmd_exp_t ce;
    send(tok);
    ce.err = 1'b1;
    ce.idx = '0;
    ce.arg = '0;
    ce.cyc = last_end + 1;
    cmd_q.push_back(ce);
    wait_idle();
  endtask

  // Monitor: pops expectations as pulses and response frames appear
  initial begin
    cmd_exp_t     ce;
    rsp_exp_t     re;
    logic [135:0] rsp_bits;
    int           rsp_len;
    int           rsp_start;
    bit           oe8_prev;
    rsp_bits  = '0;
    rsp_len   = 0;
    rsp_start = 0;
    oe8_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (in_rsp) begin
          if (rsp_q.size() > 0) void'(rsp_q.pop_front());
          in_rsp = 1'b0;
        end
        oe8_prev = 1'b0;
      end else begin
        if (vld2 || err2) begin
          if (cmd_q.size() == 0) begin
            check_eq("cmd_unexpected", {vld2, err2}, 2'b00);
          end else begin
            ce = cmd_q.pop_front();
            check_eq("cmd_kind", {vld2, err2}, ce.err ? 2'b01 : 2'b10);
            check_eq("cmd_time", cyc, ce.cyc);
            if (!ce.err) begin
              check_eq("cmd_index", idx2, ce.idx);
              check_eq("cmd_arg", arg2, ce.arg);
            end
          end
        end
        if (oe2) begin
          if (!in_rsp) begin
            in_rsp    = 1'b1;
            rsp_start = cyc;
            rsp_bits  = '0;
            rsp_len   = 0;
          end
          rsp_bits = {rsp_bits[134:0], out2};
          rsp_len++;
          oe_hi_cnt++;
        end else if (in_rsp) begin
          in_rsp = 1'b0;
          if (rsp_q.size() == 0) begin
            check_eq("rsp_unexpected", rsp_len, 0);
          end else begin
            re = rsp_q.pop_front();
            check_eq("rsp_len", rsp_len, re.len);
            check_eq("rsp_bits", rsp_bits, re.bits);
            check_eq("rsp_start", rsp_start, re.cyc);
          end
          check_eq("rsp_release_out", out2, 1'b1);
        end
        if (oe8 && !oe8_prev) begin
          if (!dut8_exp) begin
            check_eq("ncr8_unexpected", 1, 0);
          end else begin
            check_eq("ncr8_start", cyc - dut8_end, 9);
            dut8_exp = 1'b0;
          end
        end
        oe8_prev = oe8;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  // Directed and random stimulus
  initial begin
    int k;
    int oe_before;
    logic [5:0]  ridx;
    logic [31:0] rarg;

    rst  = 1'b1;
    line = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_out", out2, 1'b1);
    check_eq("rst_oe", oe2, 1'b0);
    check_eq("rst_valid", vld2, 1'b0);
    check_eq("rst_err", err2, 1'b0);
    check_eq("rst_busy", busy2, 1'b0);
    check_eq("rst_index", idx2, 6'd0);
    check_eq("rst_arg", arg2, 32'd0);
    check_eq("rst_out_n8", out8, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // CMD8 with R1 echo of the check pattern
    rsp_arg = 32'h0000_01AA;
    cmd_ok(48'h48_000001AA_87, 1'b1, 1'b1);

    // bad CRC, then good CRC with end bit 0: error pulse, no response, outputs held
    cmd_bad(48'h51_00000000_57);
    cmd_bad(48'h51_00000000_54);
    check_eq("err_hold_index", idx2, 6'd8);
    check_eq("err_hold_arg", arg2, 32'h0000_01AA);

    // CMD0: accepted, never answered
    cmd_ok(48'h40_00000000_95, 1'b0, 1'b1);
    oe_before = oe_hi_cnt;
    repeat (100) @(negedge clk);
    check_eq("cmd0_quiet", oe_hi_cnt - oe_before, 0);
    check_eq("cmd0_index", idx2, 6'd0);

    // CMD2: R1 by default, R2 with the long-response build
    rsp_arg = 32'hCAFE_F00D;
    cmd_ok(48'h42_00000000_4D, 1'b1, 1'b1);

    // another card's response on the line: silently discarded
    send(48'h08_000001AA_87);
    wait_idle();
    check_eq("foreign_index", idx2, 6'd2);

    // back-to-back: CMD0 followed immediately by CMD8
    rsp_arg = 32'h1234_5678;
    cmd_ok(48'h40_00000000_95, 1'b0, 1'b0);
    cmd_ok(48'h48_000001AA_87, 1'b1, 1'b1);

    // random indices, arguments and card status
    for (int t = 0; t < 6; t++) begin
      ridx    = 6'($urandom_range(1, 63));
      rarg    = $urandom;
      rsp_arg = $urandom;
      cmd_ok(make_cmd(ridx, rarg), 1'b1, 1'b1);
    end

    // reset in the middle of a response
    rsp_arg = 32'h0000_01AA;
    cmd_ok(48'h48_000001AA_87, 1'b1, 1'b0);
    k = 0;
    while (!oe2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check_eq("rsp_start_timeout", 0, 1);
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_oe", oe2, 1'b0);
    check_eq("mid_rst_out", out2, 1'b1);
    check_eq("mid_rst_oe_n8", oe8, 1'b0);
    check_eq("mid_rst_out_n8", out8, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_index", idx2, 6'd0);
    check_eq("post_rst_busy", busy2, 1'b0);
    repeat (2) @(negedge clk);
    cmd_ok(48'h48_000001AA_87, 1'b1, 1'b1);

    check_eq("cmd_queue_drained", cmd_q.size(), 0);
    check_eq("rsp_queue_drained", rsp_q.size(), 0);
    check_eq("ncr8_pending", dut8_exp, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
